// File: rtl/darkbus_pkg.sv
// Shared types and constants for the two-master darkbus arbiter.
package darkbus_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE = 2'd0;
  localparam arb_state_t ARB_GNT0 = 2'd1;
  localparam arb_state_t ARB_GNT1 = 2'd2;
  localparam arb_state_t ARB_DONE = 2'd3;

  localparam logic [31:0] ARB_ERR_DATA    = 32'hFFFF_FFFF;
  localparam int unsigned ARB_TIMEOUT_DEF = 255;
  localparam int unsigned ARB_WDOG_W      = 10;

  // Request payload presented by a master and forwarded to the shared bus.
  typedef struct packed {
    logic        rw;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/darkbus_wdog.sv
// Grant watchdog: counts grant cycles without slave completion.
module darkbus_wdog
  import darkbus_pkg::*;
#(
  parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic res,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [ARB_WDOG_W-1:0] cnt_q, cnt_d;
  logic                  expired_q, expired_d;

  // expired flags the cycle whose increment would make the count reach TIMEOUT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + ARB_WDOG_W'(1);
    end
    expired_d = (cnt_d == ARB_WDOG_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (res) begin
      cnt_q     <= '0;
      expired_q <= (TIMEOUT == 1);
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/darkbus_arbiter.sv
// Two-master (data/fetch) round-robin arbiter onto a single shared darkbus slave
// with a per-grant watchdog that forces an error completion.
module darkbus_arbiter
  import darkbus_pkg::*;
#(
  parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        res,
  input  logic        m0_en,
  input  logic        m0_rw,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_valid,
  output logic        m0_err,
  input  logic        m1_en,
  input  logic        m1_rw,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_valid,
  output logic        m1_err,
  output logic        s_en,
  output logic        s_rw,
  output logic [3:0]  s_be,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_valid
);

  arb_state_t  state_q, state_d;
  logic        last_gnt_q, last_gnt_d;
  logic        s_en_q, s_en_d;
  logic        m0_valid_q, m0_valid_d, m1_valid_q, m1_valid_d;
  logic        m0_err_q, m0_err_d, m1_err_q, m1_err_d;
  logic [31:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic        wd_clr, wd_inc, wd_expired;
  bus_req_t    m0_req, m1_req, s_req;

  darkbus_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .res     (res),
    .clr     (wd_clr),
    .inc     (wd_inc),
    .expired (wd_expired)
  );

  assign m0_req = {m0_rw, m0_be, m0_addr, m0_wdata};
  assign m1_req = {m1_rw, m1_be, m1_addr, m1_wdata};

  // Shared bus carries the granted master's request, zero otherwise.
  always_comb begin
    s_req = '0;
    case (state_q)
      ARB_GNT0: s_req = m0_req;
      ARB_GNT1: s_req = m1_req;
      default:  s_req = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    wd_clr     = 1'b0;
    wd_inc     = 1'b0;
    m0_valid_d = 1'b0;
    m1_valid_d = 1'b0;
    m0_err_d   = 1'b0;
    m1_err_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    case (state_q)
      ARB_IDLE: begin
        if (m0_en && (!m1_en || last_gnt_q)) begin
          state_d    = ARB_GNT0;
          last_gnt_d = 1'b0;
          wd_clr     = 1'b1;
        end else if (m1_en) begin
          state_d    = ARB_GNT1;
          last_gnt_d = 1'b1;
          wd_clr     = 1'b1;
        end
      end
      ARB_GNT0, ARB_GNT1: begin
        // A slave response wins over a simultaneous watchdog expiry.
        if (s_valid || wd_expired) begin
          state_d = ARB_DONE;
          if (state_q == ARB_GNT0) begin
            m0_valid_d = 1'b1;
            m0_err_d   = !s_valid;
            if (!s_valid) begin
              m0_rdata_d = ARB_ERR_DATA;
            end else if (!s_req.rw) begin
              m0_rdata_d = s_rdata;
            end
          end else begin
            m1_valid_d = 1'b1;
            m1_err_d   = !s_valid;
            if (!s_valid) begin
              m1_rdata_d = ARB_ERR_DATA;
            end else if (!s_req.rw) begin
              m1_rdata_d = s_rdata;
            end
          end
        end else begin
          wd_inc = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    s_en_d = (state_d == ARB_GNT0) || (state_d == ARB_GNT1);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q    <= ARB_IDLE;
      last_gnt_q <= 1'b1;
      s_en_q     <= 1'b0;
      m0_valid_q <= 1'b0;
      m1_valid_q <= 1'b0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      s_en_q     <= s_en_d;
      m0_valid_q <= m0_valid_d;
      m1_valid_q <= m1_valid_d;
      m0_err_q   <= m0_err_d;
      m1_err_q   <= m1_err_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign s_en     = s_en_q;
  assign s_rw     = s_req.rw;
  assign s_be     = s_req.be;
  assign s_addr   = s_req.addr;
  assign s_wdata  = s_req.wdata;
  assign m0_valid = m0_valid_q;
  assign m1_valid = m1_valid_q;
  assign m0_err   = m0_err_q;
  assign m1_err   = m1_err_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

endmodule
